// File: rtl/carga_colores.sv
// carga_colores: loads three colour intensities from switches (R, G, B) and
// converts them to motor cycle counts. It issues a one-cycle enter pulse to
// temporizador, then blocks further loads while the timer is dispensing.
module carga_colores #(
    parameter int IN_W       = 8,
    parameter int MAX_CICLOS = 15,
    parameter int DEB_CYC    = 3
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            boton,
    input  logic            borrar,
    input  logic [IN_W-1:0] valor,
    output logic [4:0]      ciclos_R,
    output logic [4:0]      ciclos_G,
    output logic [4:0]      ciclos_B,
    output logic            enter,
    output logic [1:0]      etapa,
    output logic            ocupado
);

    localparam int PROD_W = IN_W + 5;
    localparam int CNT_W  = $clog2(DEB_CYC + 1);

    typedef enum logic [1:0] {
        ESPERA_R = 2'd0,
        ESPERA_G = 2'd1,
        ESPERA_B = 2'd2,
        DISPARO  = 2'd3
    } estado_t;

    estado_t          estado;
    estado_t          estado_sig;
    logic             sinc_1;
    logic             sinc_2;
    logic             nivel_deb;
    logic             nivel_prev;
    logic [CNT_W-1:0] cuenta_deb;
    logic             pulso;
    logic [5:0]       cuenta_ocupado;
    logic [PROD_W-1:0] producto;
    logic [PROD_W-1:0] cociente;
    logic [4:0]       conv;
    logic             captura_r;
    logic             captura_g;
    logic             captura_b;
    logic             limpiar;

    // Two-flop synchronizer for the asynchronous push button
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sinc_1 <= 1'b0;
            sinc_2 <= 1'b0;
        end else begin
            sinc_1 <= boton;
            sinc_2 <= sinc_1;
        end
    end

    // Debouncer: accept a new level after DEB_CYC consecutive differing samples
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            nivel_deb  <= 1'b0;
            cuenta_deb <= '0;
        end else if (sinc_2 != nivel_deb) begin
            if (cuenta_deb == CNT_W'(DEB_CYC - 1)) begin
                nivel_deb  <= sinc_2;
                cuenta_deb <= '0;
            end else begin
                cuenta_deb <= cuenta_deb + 1'b1;
            end
        end else begin
            cuenta_deb <= '0;
        end
    end

    // Delayed copy of the debounced level for rising-edge detection
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            nivel_prev <= 1'b0;
        end else begin
            nivel_prev <= nivel_deb;
        end
    end

    assign pulso = nivel_deb & ~nivel_prev;

    // Intensity to cycle count: scale into 0..MAX_CICLOS, clamping for safety
    always_comb begin
        producto = PROD_W'(valor) * PROD_W'(MAX_CICLOS + 1);
        cociente = producto >> IN_W;
        conv     = cociente[4:0];
        if (cociente > PROD_W'(MAX_CICLOS)) begin
            conv = 5'(MAX_CICLOS);
        end
    end

    // FSM state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            estado <= ESPERA_R;
        end else begin
            estado <= estado_sig;
        end
    end

    // Next-state and capture strobes; borrar has priority over a press
    always_comb begin
        estado_sig = estado;
        captura_r  = 1'b0;
        captura_g  = 1'b0;
        captura_b  = 1'b0;
        limpiar    = 1'b0;
        if (estado == DISPARO) begin
            estado_sig = ESPERA_R;
        end else if (!ocupado) begin
            if (borrar) begin
                estado_sig = ESPERA_R;
                limpiar    = 1'b1;
            end else if (pulso) begin
                case (estado)
                    ESPERA_R: begin
                        captura_r  = 1'b1;
                        estado_sig = ESPERA_G;
                    end
                    ESPERA_G: begin
                        captura_g  = 1'b1;
                        estado_sig = ESPERA_B;
                    end
                    ESPERA_B: begin
                        captura_b  = 1'b1;
                        estado_sig = DISPARO;
                    end
                    default: begin
                        estado_sig = ESPERA_R;
                    end
                endcase
            end
        end
    end

    // Cycle count registers, changed only on capture or clear
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ciclos_R <= 5'd0;
            ciclos_G <= 5'd0;
            ciclos_B <= 5'd0;
        end else if (limpiar) begin
            ciclos_R <= 5'd0;
            ciclos_G <= 5'd0;
            ciclos_B <= 5'd0;
        end else begin
            if (captura_r) ciclos_R <= conv;
            if (captura_g) ciclos_G <= conv;
            if (captura_b) ciclos_B <= conv;
        end
    end

    // Registered start pulse, high for the single DISPARO cycle
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            enter <= 1'b0;
        end else begin
            enter <= (estado_sig == DISPARO);
        end
    end

    // Busy counter covering the timer's three (ciclos+1)-cycle phases
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cuenta_ocupado <= 6'd0;
        end else if (estado == DISPARO) begin
            cuenta_ocupado <= 6'(ciclos_R) + 6'(ciclos_G) + 6'(ciclos_B) + 6'd3;
        end else if (cuenta_ocupado != 6'd0) begin
            cuenta_ocupado <= cuenta_ocupado - 6'd1;
        end
    end

    assign ocupado = (cuenta_ocupado != 6'd0);
    assign etapa   = estado;

endmodule
